// File: rtl/aiken_if.sv
// Handshake bundle between a 2421 digit source and the Aiken-to-BCD deserializer.
interface aiken_if #(
  parameter int unsigned NDIG = 4
);
  localparam int unsigned NW = $clog2(NDIG + 1);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_digit;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_bcd;
  logic [NW-1:0]     out_ndig;
  logic              out_err;

  // Digit source / word consumer side
  modport master (
    output in_valid, in_digit, flush, out_ready,
    input  in_ready, out_valid, out_bcd, out_ndig, out_err
  );

  // Deserializer side
  modport slave (
    input  in_valid, in_digit, flush, out_ready,
    output in_ready, out_valid, out_bcd, out_ndig, out_err
  );
endinterface

// File: rtl/aiken_to_bcd_deser.sv
// Aiken (2421) digit stream to packed 8421 BCD word deserializer.
// Digit 0 lands in the most-significant nibble; invalid codes are stored as
// zero and flag the word. Optional macro AIKEN_ERR_CNT_EN adds err_cnt, a
// saturating count of invalid digits accepted since reset.
module aiken_to_bcd_deser #(
  parameter int unsigned NDIG = 4
) (
  input  logic       clk,
  input  logic       rst,
  aiken_if.slave     bus
`ifdef AIKEN_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned AW = 4 * NDIG;
  localparam int unsigned CW = $clog2(NDIG);
  localparam int unsigned NW = $clog2(NDIG + 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_asm;
  logic            r_err;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [AW-1:0]   r_out_bcd;
  logic [NW-1:0]   r_out_ndig;
  logic            r_out_err;

  logic [3:0]      w_dec;
  logic            w_inv;
  logic            w_accept;
  logic            w_last;
  logic            w_close;
  logic [NW-1:0]   w_held;
  logic [AW-1:0]   w_asm_next;

  // 2421 to 8421 decode; anything outside the Aiken set reads as zero + error
  always_comb begin
    w_dec = 4'd0;
    w_inv = 1'b0;
    case (bus.in_digit)
      4'b0000: w_dec = 4'd0;
      4'b0001: w_dec = 4'd1;
      4'b0010: w_dec = 4'd2;
      4'b0011: w_dec = 4'd3;
      4'b0100: w_dec = 4'd4;
      4'b1011: w_dec = 4'd5;
      4'b1100: w_dec = 4'd6;
      4'b1101: w_dec = 4'd7;
      4'b1110: w_dec = 4'd8;
      4'b1111: w_dec = 4'd9;
      default: w_inv = 1'b1;
    endcase
  end

  // Accept qualification, close decision and assembly word including this cycle's digit
  always_comb begin
    w_accept   = bus.in_valid & (r_state == S_COLLECT);
    w_held     = NW'(r_cnt) + NW'(w_accept);
    w_last     = w_accept & (r_cnt == CW'(NDIG - 1));
    w_close    = w_last | (bus.flush & (r_state == S_COLLECT) & (w_held != '0));
    w_asm_next = r_asm;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (w_accept && (r_cnt == CW'(i))) begin
        w_asm_next[4*(int'(NDIG)-1-i) +: 4] = w_dec;
      end
    end
  end

  // Collect/hold state machine with registered handshake and word outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_cnt       <= '0;
      r_asm       <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_ndig  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_close) begin
            r_state     <= S_HOLD;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_bcd   <= w_asm_next;
            r_out_ndig  <= w_held;
            r_out_err   <= r_err | (w_accept & w_inv);
            r_cnt       <= '0;
            r_asm       <= '0;
            r_err       <= 1'b0;
          end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            r_asm <= w_asm_next;
            r_err <= r_err | w_inv;
          end
        end
        S_HOLD: begin
          // Word handed over; the assembly side is already clear
          if (bus.out_ready) begin
            r_state     <= S_COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bcd   <= '0;
            r_out_ndig  <= '0;
            r_out_err   <= 1'b0;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_err       <= 1'b0;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

`ifdef AIKEN_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of invalid digits accepted since reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && w_inv && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bcd   = r_out_bcd;
  assign bus.out_ndig  = r_out_ndig;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_aiken_to_bcd_deser.sv
// Self-checking bench for aiken_to_bcd_deser: directed words with literal
// expectations, then randomized traffic against a queue-based word model.
module tb_aiken_to_bcd_deser;

  localparam int unsigned NDIG = 4;
  localparam int unsigned AW   = 4 * NDIG;

  logic clk;
  logic rst;

  aiken_if #(.NDIG(NDIG)) bus ();

`ifdef AIKEN_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  aiken_to_bcd_deser #(.NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef AIKEN_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 2421 code -> decimal value, -1 for a non-Aiken code
  int dec_tab [16] = '{0, 1, 2, 3, 4, -1, -1, -1, -1, -1, -1, 5, 6, 7, 8, 9};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init = 1'b0;
  bit          m_hold = 1'b0;
  int          m_digs[$];
  bit          m_err  = 1'b0;
  logic [AW-1:0] m_word = '0;
  int          m_n    = 0;
  bit          m_werr = 1'b0;
  int          m_ecnt = 0;

  task automatic model_step();
    int d;
    if (rst) begin
      m_init = 1'b1;
      m_hold = 1'b0;
      m_digs.delete();
      m_err  = 1'b0;
      m_ecnt = 0;
    end else if (m_init) begin
      if (!m_hold) begin
        if (bus.in_valid) begin
          d = dec_tab[bus.in_digit];
          if (d < 0) begin
            m_err = 1'b1;
            if (m_ecnt < 255) m_ecnt++;
            d = 0;
          end
          m_digs.push_back(d);
        end
        if (m_digs.size() == int'(NDIG) || (bus.flush && m_digs.size() > 0)) begin
          m_hold = 1'b1;
          m_word = '0;
          foreach (m_digs[i]) m_word = m_word | (AW'(m_digs[i]) << (4 * (int'(NDIG) - 1 - i)));
          m_n    = m_digs.size();
          m_werr = m_err;
          m_digs.delete();
          m_err  = 1'b0;
        end
      end else if (bus.out_ready) begin
        m_hold = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare DUT against the model every cycle once reset has been seen
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_hold));
      check("in_ready",  32'(bus.in_ready),  32'(!m_hold));
      if (m_hold) begin
        check("out_bcd",  32'(bus.out_bcd),  32'(m_word));
        check("out_ndig", 32'(bus.out_ndig), 32'(m_n));
        check("out_err",  32'(bus.out_err),  32'(m_werr));
      end
`ifdef AIKEN_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs; returns 2 time units after the capturing edge
  task automatic drive(input bit v, input logic [3:0] d, input bit f, input bit ordy, input bit r);
    bus.in_valid  = v;
    bus.in_digit  = d;
    bus.flush     = f;
    bus.out_ready = ordy;
    rst           = r;
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    drive(1'b1, a, 1'b0, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0);
    drive(1'b1, c, 1'b0, 1'b0, 1'b0);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_word(input string nm, input logic [AW-1:0] bcd, input int n, input bit e);
    check({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({nm, ".ready"}, 32'(bus.in_ready),  32'd0);
    check({nm, ".bcd"},   32'(bus.out_bcd),   32'(bcd));
    check({nm, ".ndig"},  32'(bus.out_ndig),  32'(n));
    check({nm, ".err"},   32'(bus.out_err),   32'(e));
  endtask

  task automatic release_word();
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("release.in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_digit  = 4'b0000;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    #2;
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Reset state
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.in_ready",  32'(bus.in_ready),  32'd1);
    check("rst.out_bcd",   32'(bus.out_bcd),   32'd0);
    check("rst.out_ndig",  32'(bus.out_ndig),  32'd0);
    check("rst.out_err",   32'(bus.out_err),   32'd0);

    // Full word, lower codes
    send_word(4'b0001, 4'b0010, 4'b0011, 4'b0100);
    check_word("w1234", 16'h1234, 4, 1'b0);
    release_word();

    // Upper Aiken codes
    send_word(4'b1011, 4'b1100, 4'b1101, 4'b1111);
    check_word("w5679", 16'h5679, 4, 1'b0);
    release_word();
    send_word(4'b1110, 4'b0000, 4'b0000, 4'b0000);
    check_word("w8000", 16'h8000, 4, 1'b0);
    release_word();

    // Invalid code, then backpressure for 5 cycles with flush ignored in hold
    send_word(4'b0001, 4'b0110, 4'b0010, 4'b0011);
    check_word("w1023", 16'h1023, 4, 1'b1);
`ifdef AIKEN_ERR_CNT_EN
    check("err_cnt1", 32'(err_cnt), 32'd1);
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0100, (i == 2), 1'b0, 1'b0);
      check_word("bp", 16'h1023, 4, 1'b1);
    end
    // Handover cycle: offered digit must be ignored
    drive(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
    check("handover.in_ready",  32'(bus.in_ready),  32'd1);
    check("handover.out_valid", 32'(bus.out_valid), 32'd0);
    send_word(4'b0100, 4'b0011, 4'b0010, 4'b0001);
    check_word("w4321", 16'h4321, 4, 1'b0);
    release_word();

    // Flush with a digit in the same cycle
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    check_word("flush2", 16'h8100, 2, 1'b0);
    release_word();
    // Flush with nothing held is ignored
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("flush_empty.out_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("flush_empty.out_valid2", 32'(bus.out_valid), 32'd0);

    // Reset mid-word discards the partial word
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1);
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("midrst.out_valid2", 32'(bus.out_valid), 32'd0);
    send_word(4'b0100, 4'b0001, 4'b0001, 4'b0001);
    check_word("w4111", 16'h4111, 4, 1'b0);
`ifdef AIKEN_ERR_CNT_EN
    check("err_cnt_rst", 32'(err_cnt), 32'd0);
`endif
    release_word();

    // Randomized traffic; the per-cycle model compare does the checking
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 199) == 0));
    end

    drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aiken_to_bcd_deser.md
Name: aiken_to_bcd_deser

Overview:
- Receive side of the 8421-to-2421 (Aiken) conversion path.
- Accepts one 2421-coded digit per handshake, decodes it to 8421 BCD and packs NDIG digits into one BCD word, first digit in the most-significant nibble.
- Presents the packed word on a valid/ready output; flags non-Aiken codes.
- Sits between a 2421 digit source (link or serial stage) and BCD arithmetic or display logic.

Parameters:
- NDIG, 4, digits per output word; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_digit is valid this cycle
- in_ready  output  1  block accepts a digit this cycle
- in_digit  input  4  2421 code, bit 3 = weight-2 MSB
- flush  input  1  close a partial word (see Behaviour)
- out_valid  output  1  out_bcd/out_ndig/out_err valid
- out_ready  input  1  consumer accepts the word
- out_bcd  output  4*NDIG  packed BCD, digit 0 in [4*NDIG-1:4*NDIG-4]
- out_ndig  output  $clog2(NDIG+1)  number of digits in the word
- out_err  output  1  at least one invalid code in the word

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Decode table (2421 to 8421):
  - 0000→0, 0001→1, 0010→2, 0011→3, 0100→4
  - 1011→5, 1100→6, 1101→7, 1110→8, 1111→9
- Invalid codes (0101, 0110, 0111, 1000, 1001, 1010):
  - stored as 0000
  - set the word's sticky error bit
  - the digit still consumes a slot
- Digit accept: in_valid & in_ready.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Digit counter cnt (0..NDIG-1) and assembly register asm_reg (4*NDIG). Each accepted digit is written to nibble index cnt; cnt increments.
- COLLECT→HOLD, registered, taken on the clock edge of either:
  - an accept with cnt==NDIG-1: out_ndig=NDIG
  - flush=1 with at least one digit held after this cycle's accept: out_ndig=number held
- Unfilled nibbles read 0000.
- Flush with in_valid in the same cycle: the digit is accepted first, then the word closes including that digit.
- Flush with no digits held and no accept: ignored, stay in COLLECT.
- Flush in HOLD: ignored.
- HOLD→COLLECT on out_ready. On that edge: cnt=0, asm_reg cleared, error bit cleared.
- No digit is accepted in the handover cycle. Throughput: NDIG+1 cycles per full word.
- In HOLD, out_bcd, out_ndig and out_err are held stable while out_ready=0.
- Latency: out_valid asserts on the cycle after the accept of the last digit.
- Reset values:
  - state=COLLECT, cnt=0, asm_reg=0, error=0
  - out_valid=0, out_bcd=0, out_ndig=0, out_err=0, in_ready=1 (from the cycle after rst)
- Reset mid-word or in HOLD: the partial or held word is discarded, with no output pulse. rst has priority over every other input.
- in_digit is ignored when in_valid=0. out_ready is ignored in COLLECT.

Optional Feature:
- Macro: AIKEN_ERR_CNT_EN
- Defined:
  - adds output port err_cnt [7:0]: a count of invalid digits accepted
  - saturates at 8'hFF
  - cleared only by rst
  - increments on the accept cycle, visible the next cycle
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Full word, NDIG=4: accept digits 0001, 0010, 0011, 0100 on consecutive cycles → next cycle out_valid=1, out_bcd=16'h1234, out_ndig=4, out_err=0, in_ready=0.
- Upper Aiken codes: 1011, 1100, 1101, 1111 → out_bcd=16'h5679, out_err=0. Then 1110, 0000, 0000, 0000 → 16'h8000.
- Invalid code: 0001, 0110, 0010, 0011 → out_bcd=16'h1023, out_err=1. Next word is all valid → out_err=0. With AIKEN_ERR_CNT_EN, err_cnt=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_bcd, out_ndig, out_err stable and in_ready=0 throughout. On the cycle with out_ready=1: in_valid is ignored; the next cycle in_ready=1.
- Flush: 1110, then 0001 with flush=1 in the same cycle → out_bcd=16'h8100, out_ndig=2. Flush with cnt=0 and in_valid=0 → no out_valid.
- Reset mid-word: accept 0001, 0010, 0011, then rst=1 for one cycle → out_valid stays 0. Then 0100, 0001, 0001, 0001 → out_bcd=16'h4111.
